// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, status flag indices and FSM states for the sequential ALU
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_INV = 4'd7;
    localparam logic [3:0] OP_TWC = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;
    localparam logic [3:0] OP_DEC = 4'd10;
    localparam logic [3:0] OP_LSR = 4'd11;
    localparam logic [3:0] OP_ASR = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [3:0] OP_SEF = 4'd14;
    localparam logic [3:0] OP_CLF = 4'd15;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_RUN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: WIDTH-cycle unsigned shift-add multiplier.
// done is high during the final step; product then already includes that step.
module seq_alu_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] r_mc;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mp;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    assign busy    = r_busy;
    assign done    = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign product = r_acc + (r_mp[0] ? r_mc : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mc   <= '0;
            r_acc  <= '0;
            r_mp   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (go && !r_busy) begin
            r_mc   <= {{WIDTH{1'b0}}, a};
            r_acc  <= '0;
            r_mp   <= b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc  <= product;
            r_mc   <= r_mc << 1;
            r_mp   <= r_mp >> 1;
            r_cnt  <= r_cnt + CW'(1);
            r_busy <= !done;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with start/busy/done handshake, status register
// and a multi-cycle multiplier producing a double-width product.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SR_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3:0]              op,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [$clog2(SR_W)-1:0] flag_sel,
    input  logic                    status_load,
    input  logic [SR_W-1:0]         status_in,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        result_lo,
    output logic [WIDTH-1:0]        result_hi,
    output logic [SR_W-1:0]         status
);

    state_t              r_state;
    logic                r_done;
    logic [WIDTH-1:0]    r_lo;
    logic [WIDTH-1:0]    r_hi;
    logic [SR_W-1:0]     r_status;

    logic [WIDTH-1:0]    w_bx;
    logic                w_cin;
    logic [WIDTH:0]      w_arith;
    logic [WIDTH:0]      w_res;
    logic                w_av;
    logic                w_fs_ok;
    logic [SR_W-1:0]     w_st;
    logic [SR_W-1:0]     w_mul_st;
    logic                w_mul_go;
    logic                w_mul_busy;
    logic                w_mul_done;
    logic [2*WIDTH-1:0]  w_prod;

    assign busy      = w_mul_busy;
    assign done      = r_done;
    assign result_lo = r_lo;
    assign result_hi = r_hi;
    assign status    = r_status;
    assign w_mul_go  = (r_state == ST_IDLE) && start && (op == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .go      (w_mul_go),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_prod)
    );

    // Bit WIDTH of w_res carries C: adder carry-out, or the shifted-out a[0]
    always_comb begin
        w_bx    = (op == OP_SUB || op == OP_SBC) ? ~b : b;
        w_cin   = op == OP_ADD ? 1'b0 : op == OP_SUB ? 1'b1 : r_status[FLG_C];
        w_arith = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_cin};
        w_av    = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_arith[WIDTH-1] != a[WIDTH-1]);
        w_fs_ok = 32'(flag_sel) < SR_W;
        w_res   = '0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: w_res = w_arith;
            OP_AND:  w_res = {1'b0, a & b};
            OP_OR:   w_res = {1'b0, a | b};
            OP_XOR:  w_res = {1'b0, a ^ b};
            OP_INV:  w_res = {1'b0, ~a};
            OP_TWC:  w_res = {1'b0, ~a} + (WIDTH+1)'(1);
            OP_INC:  w_res = {1'b0, a} + (WIDTH+1)'(1);
            OP_DEC:  w_res = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
            OP_LSR:  w_res = {a[0], 1'b0, a[WIDTH-1:1]};
            OP_ASR:  w_res = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
            default: w_res = '0;
        endcase
        w_st = r_status;
        if (!(op inside {OP_MUL, OP_SEF, OP_CLF})) begin
            w_st[FLG_Z] = (w_res[WIDTH-1:0] == '0);
            w_st[FLG_N] = w_res[WIDTH-1];
        end
        if (op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_TWC, OP_INC, OP_DEC, OP_LSR, OP_ASR})
            w_st[FLG_C] = w_res[WIDTH];
        if (op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC})
            w_st[FLG_V] = w_av;
        if (op == OP_SEF && w_fs_ok)
            w_st[flag_sel] = 1'b1;
        if (op == OP_CLF && w_fs_ok)
            w_st[flag_sel] = 1'b0;
        w_mul_st        = r_status;
        w_mul_st[FLG_Z] = (w_prod == '0);
        w_mul_st[FLG_N] = w_prod[2*WIDTH-1];
        w_mul_st[FLG_C] = 1'b0;
        w_mul_st[FLG_V] = (w_prod[2*WIDTH-1:WIDTH] != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_done   <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_status <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && op == OP_MUL) begin
                        r_state <= ST_MUL_RUN;
                    end else if (start) begin
                        r_state  <= ST_FIN;
                        r_done   <= 1'b1;
                        r_status <= w_st;
                        if (op != OP_SEF && op != OP_CLF) begin
                            r_lo <= w_res[WIDTH-1:0];
                            r_hi <= '0;
                        end
                    end else if (status_load) begin
                        r_status <= status_in;
                    end
                end
                ST_MUL_RUN: begin
                    if (w_mul_done) begin
                        r_state  <= ST_FIN;
                        r_done   <= 1'b1;
                        r_lo     <= w_prod[WIDTH-1:0];
                        r_hi     <= w_prod[2*WIDTH-1:WIDTH];
                        r_status <= w_mul_st;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven scoreboard bench for seq_alu (WIDTH=16, SR_W=8)
module tb_seq_alu;
    import seq_alu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [7:0]  st;
    } vec_t;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [7:0]  st;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        status_load = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  flag_sel = '0;
    logic [7:0]  status_in = '0;
    logic        busy;
    logic        done;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic [7:0]  status;

    int   total = 0;
    int   passed = 0;
    vec_t vt[$];
    exp_t sb[$];

    seq_alu #(.WIDTH(16), .SR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flag_sel    (flag_sel),
        .status_load (status_load),
        .status_in   (status_in),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .status      (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Issue one op, wait (bounded) for done, then compare against the scoreboard.
    task automatic do_op(input logic [3:0] o, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [2:0] fs, input logic [15:0] elo, input logic [15:0] ehi,
                         input logic [7:0] est, input bit intrude);
        int   n = 0;
        int   nb = 0;
        exp_t e;
        sb.push_back('{elo, ehi, est, (o == OP_MUL) ? 16 : 0});
        start = 1'b1; op = o; a = ia; b = ib; flag_sel = fs;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && n < 100) begin
            if (busy) nb++;
            if (intrude && n == 4) begin
                start = 1'b1;
                op = OP_ADD;
            end else start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("busy_cycles", nb, e.lat);
        chk("result_lo", result_lo, e.lo);
        chk("result_hi", result_hi, e.hi);
        chk("status", status, e.st);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        vt.push_back('{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 8'h05});
        vt.push_back('{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 8'h0A});
        vt.push_back('{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 8'h02});
        vt.push_back('{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 8'h0D});
        vt.push_back('{OP_ADC, 16'h0001, 16'h0002, 16'h0004, 16'h0000, 8'h00});
        vt.push_back('{OP_SBC, 16'h0005, 16'h0003, 16'h0001, 16'h0000, 8'h04});
        vt.push_back('{OP_SBC, 16'h0005, 16'h0003, 16'h0002, 16'h0000, 8'h04});
        vt.push_back('{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 8'h06});
        vt.push_back('{OP_OR,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h05});
        vt.push_back('{OP_XOR, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 8'h06});
        vt.push_back('{OP_INV, 16'h0000, 16'h1234, 16'hFFFF, 16'h0000, 8'h06});
        vt.push_back('{OP_TWC, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 8'h02});
        vt.push_back('{OP_TWC, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h05});
        vt.push_back('{OP_INC, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 8'h05});
        vt.push_back('{OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 8'h02});
        vt.push_back('{OP_DEC, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 8'h05});
        vt.push_back('{OP_LSR, 16'h8001, 16'h0000, 16'h4000, 16'h0000, 8'h04});
        vt.push_back('{OP_ASR, 16'h8002, 16'h0000, 16'hC001, 16'h0000, 8'h02});
        vt.push_back('{OP_MUL, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 8'h08});
        vt.push_back('{OP_MUL, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 8'h01});
        vt.push_back('{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 8'h0A});
        vt.push_back('{OP_ADD, 16'h0001, 16'h0001, 16'h0002, 16'h0000, 8'h00});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_lo", result_lo, 0);
        chk("reset_hi", result_hi, 0);
        chk("reset_status", status, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vt[i])
            do_op(vt[i].op, vt[i].a, vt[i].b, 3'd0, vt[i].lo, vt[i].hi, vt[i].st, 1'b0);

        // A start presented mid-multiply must not disturb it
        do_op(OP_MUL, 16'h1234, 16'h5678, 3'd0, 16'h0060, 16'h0626, 8'h08, 1'b1);

        // Async reset partway through a multiply
        start = 1'b1; op = OP_MUL; a = 16'h1234; b = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_mul_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_lo", result_lo, 0);
        chk("rst_mid_hi", result_hi, 0);
        chk("rst_mid_status", status, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_op(OP_ADD, 16'h0002, 16'h0003, 3'd0, 16'h0005, 16'h0000, 8'h00, 1'b0);

        // Flag set/clear by index
        do_op(OP_SEF, 16'hAAAA, 16'h5555, 3'd5, 16'h0005, 16'h0000, 8'h20, 1'b0);
        do_op(OP_LSR, 16'h0003, 16'h0000, 3'd0, 16'h0001, 16'h0000, 8'h24, 1'b0);
        do_op(OP_CLF, 16'hFFFF, 16'hFFFF, 3'd5, 16'h0001, 16'h0000, 8'h04, 1'b0);

        // Status restore, then collision with start
        status_load = 1'b1; status_in = 8'hA5;
        @(posedge clk); #1;
        status_load = 1'b0;
        chk("status_load", status, 8'hA5);
        status_load = 1'b1; status_in = 8'hFF;
        do_op(OP_ADD, 16'h0001, 16'h0001, 3'd0, 16'h0002, 16'h0000, 8'hA0, 1'b0);
        status_load = 1'b0;

        // Start held into FIN is ignored
        start = 1'b1; op = OP_INC; a = 16'h0001;
        @(posedge clk); #1;
        chk("fin_done", done, 1);
        chk("fin_lo", result_lo, 16'h0002);
        a = 16'h0005;
        @(posedge clk); #1;
        start = 1'b0;
        chk("fin_start_ignored", done, 0);
        chk("fin_lo_hold", result_lo, 16'h0002);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
